// File: rtl/chunk_deposit_driver_if.sv
// Chunked write bus plus driven-signal observation for chunk_deposit_driver.
// The master side offers 32-bit chunks; the slave side drives sig and status.
interface chunk_deposit_driver_if #(
    parameter int NBITS = 1
);
    localparam int NCHUNKS = (NBITS + 31) / 32;
    localparam int IDX_W   = $clog2(NCHUNKS + 1);

    logic              wr_valid;
    logic              wr_ready;
    logic [31:0]       wr_data;
    logic              wr_abort;
    logic [NBITS-1:0]  sig;
    logic              sig_changed;
    logic [31:0]       change_count;
    logic [IDX_W-1:0]  chunk_idx;
    logic              busy;

    modport master (
        output wr_valid, wr_data, wr_abort,
        input  wr_ready, sig, sig_changed, change_count, chunk_idx, busy
    );

    modport slave (
        input  wr_valid, wr_data, wr_abort,
        output wr_ready, sig, sig_changed, change_count, chunk_idx, busy
    );
endinterface

// File: rtl/chunk_deposit_driver.sv
// Collects NBITS-wide values as 32-bit chunks and drives them onto sig; CHUNK_DEPOSIT_FILTER_EN suppresses same-value counts.
// Latency: sig/sig_changed update one edge after the last chunk is accepted.
// Backpressure: wr_ready drops for the single COMMIT cycle only; registered, no path from wr_valid.
module chunk_deposit_driver #(
    parameter int NBITS = 1
) (
    input logic                   clk,
    input logic                   rst,
    chunk_deposit_driver_if.slave bus
);
    localparam int NCHUNKS = (NBITS + 31) / 32;
    localparam int IDX_W   = $clog2(NCHUNKS + 1);
    localparam int SW      = NCHUNKS * 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_COMMIT
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] chunk_idx_q, chunk_idx_d;
    logic [SW-1:0]    staging_q, staging_d;
    logic [NBITS-1:0] sig_q, sig_d;
    logic             sig_changed_q, sig_changed_d;
    logic [31:0]      change_count_q, change_count_d;
    logic             wr_ready_q, wr_ready_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d        = state_q;
        chunk_idx_d    = chunk_idx_q;
        staging_d      = staging_q;
        sig_d          = sig_q;
        sig_changed_d  = 1'b0;
        change_count_d = change_count_q;

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                // Abort outranks a simultaneous transfer: the offered word is dropped.
                if (bus.wr_abort) begin
                    staging_d   = '0;
                    chunk_idx_d = '0;
                    state_d     = ST_IDLE;
                end else if (bus.wr_valid) begin
                    staging_d[32*int'(chunk_idx_q) +: 32] = bus.wr_data;
                    if (chunk_idx_q == LAST_IDX) begin
                        chunk_idx_d = '0;
                        state_d     = ST_COMMIT;
                    end else begin
                        chunk_idx_d = chunk_idx_q + IDX_W'(1);
                        state_d     = ST_COLLECT;
                    end
                end
            end
            ST_COMMIT: begin
                sig_d = staging_q[NBITS-1:0];
`ifdef CHUNK_DEPOSIT_FILTER_EN
                // Only count commits that a downstream edge probe could observe.
                if (staging_q[NBITS-1:0] != sig_q) begin
                    sig_changed_d  = 1'b1;
                    change_count_d = change_count_q + 32'd1;
                end
`else
                sig_changed_d  = 1'b1;
                change_count_d = change_count_q + 32'd1;
`endif
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                chunk_idx_d = '0;
            end
        endcase

        wr_ready_d = (state_d != ST_COMMIT);
        busy_d     = (chunk_idx_d != '0) || (state_d == ST_COMMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            chunk_idx_q    <= '0;
            staging_q      <= '0;
            sig_q          <= '0;
            sig_changed_q  <= 1'b0;
            change_count_q <= '0;
            wr_ready_q     <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            chunk_idx_q    <= chunk_idx_d;
            staging_q      <= staging_d;
            sig_q          <= sig_d;
            sig_changed_q  <= sig_changed_d;
            change_count_q <= change_count_d;
            wr_ready_q     <= wr_ready_d;
            busy_q         <= busy_d;
        end
    end

    // Padding bits of the last chunk are stored but never reach sig.
    if (SW > NBITS) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^staging_q[SW-1:NBITS];
    end

    assign bus.wr_ready     = wr_ready_q;
    assign bus.sig          = sig_q;
    assign bus.sig_changed  = sig_changed_q;
    assign bus.change_count = change_count_q;
    assign bus.chunk_idx    = chunk_idx_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_chunk_deposit_driver.sv
// Scoreboarded bench for chunk_deposit_driver across several NBITS instances.
// Instances: 0:NBITS=1 1:NBITS=4 2:NBITS=32 3:NBITS=33 4:NBITS=64; one is driven at a time.
module tb_chunk_deposit_driver;
    logic        clk;
    logic        rst;
    logic [2:0]  sel;
    logic        v;
    logic        ab;
    logic [31:0] d;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0]  id;
        logic [63:0] s;
        logic [31:0] c;
    } exp_t;

    exp_t        exp_q[$];
    int          exp_cnt[5];

    logic [63:0] sig_a[5];
    logic        chg_a[5];
    logic [31:0] cnt_a[5];
    logic        rdy_a[5];
    logic        busy_a[5];
    logic [7:0]  idx_a[5];

    chunk_deposit_driver_if #(.NBITS(1))  if0 ();
    chunk_deposit_driver_if #(.NBITS(4))  if1 ();
    chunk_deposit_driver_if #(.NBITS(32)) if2 ();
    chunk_deposit_driver_if #(.NBITS(33)) if3 ();
    chunk_deposit_driver_if #(.NBITS(64)) if4 ();

    chunk_deposit_driver #(.NBITS(1))  u0 (.clk(clk), .rst(rst), .bus(if0));
    chunk_deposit_driver #(.NBITS(4))  u1 (.clk(clk), .rst(rst), .bus(if1));
    chunk_deposit_driver #(.NBITS(32)) u2 (.clk(clk), .rst(rst), .bus(if2));
    chunk_deposit_driver #(.NBITS(33)) u3 (.clk(clk), .rst(rst), .bus(if3));
    chunk_deposit_driver #(.NBITS(64)) u4 (.clk(clk), .rst(rst), .bus(if4));

    assign if0.wr_valid = v && (sel == 3'd0);
    assign if1.wr_valid = v && (sel == 3'd1);
    assign if2.wr_valid = v && (sel == 3'd2);
    assign if3.wr_valid = v && (sel == 3'd3);
    assign if4.wr_valid = v && (sel == 3'd4);
    assign if0.wr_abort = ab && (sel == 3'd0);
    assign if1.wr_abort = ab && (sel == 3'd1);
    assign if2.wr_abort = ab && (sel == 3'd2);
    assign if3.wr_abort = ab && (sel == 3'd3);
    assign if4.wr_abort = ab && (sel == 3'd4);
    assign if0.wr_data  = d;
    assign if1.wr_data  = d;
    assign if2.wr_data  = d;
    assign if3.wr_data  = d;
    assign if4.wr_data  = d;

    assign sig_a[0] = 64'(if0.sig);
    assign sig_a[1] = 64'(if1.sig);
    assign sig_a[2] = 64'(if2.sig);
    assign sig_a[3] = 64'(if3.sig);
    assign sig_a[4] = 64'(if4.sig);
    assign chg_a[0] = if0.sig_changed;
    assign chg_a[1] = if1.sig_changed;
    assign chg_a[2] = if2.sig_changed;
    assign chg_a[3] = if3.sig_changed;
    assign chg_a[4] = if4.sig_changed;
    assign cnt_a[0] = if0.change_count;
    assign cnt_a[1] = if1.change_count;
    assign cnt_a[2] = if2.change_count;
    assign cnt_a[3] = if3.change_count;
    assign cnt_a[4] = if4.change_count;
    assign rdy_a[0] = if0.wr_ready;
    assign rdy_a[1] = if1.wr_ready;
    assign rdy_a[2] = if2.wr_ready;
    assign rdy_a[3] = if3.wr_ready;
    assign rdy_a[4] = if4.wr_ready;
    assign busy_a[0] = if0.busy;
    assign busy_a[1] = if1.busy;
    assign busy_a[2] = if2.busy;
    assign busy_a[3] = if3.busy;
    assign busy_a[4] = if4.busy;
    assign idx_a[0] = 8'(if0.chunk_idx);
    assign idx_a[1] = 8'(if1.chunk_idx);
    assign idx_a[2] = 8'(if2.chunk_idx);
    assign idx_a[3] = 8'(if3.chunk_idx);
    assign idx_a[4] = 8'(if4.chunk_idx);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [63:0] s);
        exp_t e;
        exp_cnt[i]++;
        e.id = 3'(i);
        e.s  = s;
        e.c  = 32'(exp_cnt[i]);
        exp_q.push_back(e);
    endtask

    task automatic send(input int i, input logic [31:0] w);
        sel = 3'(i);
        v   = 1'b1;
        d   = w;
        @(posedge clk);
        #1;
        v   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every sig_changed pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (chg_a[i]) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("unexpected_pulse_inst%0d", i), 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("pulse_inst%0d_id", i), 64'(i), 64'(e.id));
                    chk($sformatf("pulse_inst%0d_sig", i), sig_a[i], e.s);
                    chk($sformatf("pulse_inst%0d_count", i), 64'(cnt_a[i]), 64'(e.c));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] words[4];
    int          j;
    int          cyc;
    logic        r;

    initial begin
        rst = 1'b1;
        sel = 3'd0;
        v   = 1'b0;
        ab  = 1'b0;
        d   = 32'd0;
        for (int i = 0; i < 5; i++) exp_cnt[i] = 0;
        words[0] = 32'h1111_1111;
        words[1] = 32'h2222_2222;
        words[2] = 32'h3333_3333;
        words[3] = 32'h4444_4444;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rst_sig%0d", i), sig_a[i], 64'd0);
            chk($sformatf("rst_chg%0d", i), 64'(chg_a[i]), 64'd0);
            chk($sformatf("rst_cnt%0d", i), 64'(cnt_a[i]), 64'd0);
            chk($sformatf("rst_idx%0d", i), 64'(idx_a[i]), 64'd0);
            chk($sformatf("rst_busy%0d", i), 64'(busy_a[i]), 64'd0);
            chk($sformatf("rst_rdy%0d", i), 64'(rdy_a[i]), 64'd1);
        end
        @(posedge clk);
        #1;

        // NBITS=1: single-chunk values go straight to COMMIT
        push(0, 64'h1);
        send(0, 32'h1);
        chk("n1_rdy_commit", 64'(rdy_a[0]), 64'd0);
        idle(1);
        chk("n1_sig_one", sig_a[0], 64'h1);
        push(0, 64'h0);
        send(0, 32'h0);
        idle(2);
        chk("n1_sig_zero", sig_a[0], 64'h0);
        chk("n1_count", 64'(cnt_a[0]), 64'd2);

        // NBITS=33: upper chunk bits beyond bit 32 are discarded
        push(3, 64'h1_FFFF_FFFF);
        send(3, 32'hFFFF_FFFF);
        chk("n33_busy_c0", 64'(busy_a[3]), 64'd1);
        chk("n33_idx_c0", 64'(idx_a[3]), 64'd1);
        chk("n33_rdy_c0", 64'(rdy_a[3]), 64'd1);
        send(3, 32'h0000_0003);
        chk("n33_rdy_commit", 64'(rdy_a[3]), 64'd0);
        chk("n33_busy_commit", 64'(busy_a[3]), 64'd1);
        chk("n33_chg_early", 64'(chg_a[3]), 64'd0);
        chk("n33_idx_commit", 64'(idx_a[3]), 64'd0);
        idle(1);
        chk("n33_rdy_after", 64'(rdy_a[3]), 64'd1);
        chk("n33_busy_after", 64'(busy_a[3]), 64'd0);
        chk("n33_chg_pulse", 64'(chg_a[3]), 64'd1);
        chk("n33_sig", sig_a[3], 64'h1_FFFF_FFFF);

        // NBITS=33 abort after chunk 0 while a word is offered
        send(3, 32'hAAAA_AAAA);
        sel = 3'd3;
        v   = 1'b1;
        d   = 32'h1234_5678;
        ab  = 1'b1;
        @(posedge clk);
        #1;
        v   = 1'b0;
        ab  = 1'b0;
        chk("abort_idx", 64'(idx_a[3]), 64'd0);
        chk("abort_busy", 64'(busy_a[3]), 64'd0);
        chk("abort_sig", sig_a[3], 64'h1_FFFF_FFFF);
        chk("abort_cnt", 64'(cnt_a[3]), 64'd1);
        push(3, 64'h0_0000_1234);
        send(3, 32'h0000_1234);
        send(3, 32'h0000_0000);
        idle(2);
        chk("abort_after_cnt", 64'(cnt_a[3]), 64'd2);

        // NBITS=4: repeated identical value
        push(1, 64'h5);
        send(1, 32'h5);
        idle(1);
`ifndef CHUNK_DEPOSIT_FILTER_EN
        push(1, 64'h5);
`endif
        send(1, 32'h5);
        idle(2);
`ifdef CHUNK_DEPOSIT_FILTER_EN
        chk("repeat_cnt", 64'(cnt_a[1]), 64'd1);
`else
        chk("repeat_cnt", 64'(cnt_a[1]), 64'd2);
`endif
        chk("repeat_sig", sig_a[1], 64'h5);

        // NBITS=32: valid held high, source advances only on acceptance
        for (int k = 0; k < 4; k++) push(2, 64'(words[k]));
        sel = 3'd2;
        j   = 0;
        cyc = 0;
        v   = 1'b1;
        d   = words[0];
        while (j < 4 && cyc < 50) begin
            r = rdy_a[2];
            @(posedge clk);
            #1;
            cyc++;
            if (r) begin
                j++;
                if (j < 4) d = words[j];
            end
        end
        v = 1'b0;
        chk("stream_accepted", 64'(j), 64'd4);
        chk("stream_cycles", 64'(cyc), 64'd7);
        idle(2);
        chk("stream_cnt", 64'(cnt_a[2]), 64'd4);
        chk("stream_sig", sig_a[2], 64'h4444_4444);

        // NBITS=64: asynchronous reset during COLLECT
        send(4, 32'hDEAD_BEEF);
        chk("n64_idx_collect", 64'(idx_a[4]), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_collect_idx", 64'(idx_a[4]), 64'd0);
        chk("rst_collect_busy", 64'(busy_a[4]), 64'd0);
        chk("rst_collect_rdy", 64'(rdy_a[4]), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // NBITS=64: asynchronous reset during COMMIT, no pulse afterwards
        send(4, 32'h0000_0001);
        send(4, 32'h0000_0002);
        chk("n64_in_commit", 64'(rdy_a[4]), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_commit_rdy", 64'(rdy_a[4]), 64'd1);
        chk("rst_commit_busy", 64'(busy_a[4]), 64'd0);
        chk("rst_commit_sig", sig_a[4], 64'd0);
        chk("rst_commit_cnt", 64'(cnt_a[4]), 64'd0);
        chk("rst_commit_chg", 64'(chg_a[4]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        chk("post_rst_cnt", 64'(cnt_a[4]), 64'd0);
        chk("post_rst_sig", sig_a[4], 64'd0);

        idle(2);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/chunk_deposit_driver.md
# chunk_deposit_driver

Write-side counterpart of the chunked signal probe: accepts a value for an NBITS-wide signal as a sequence of 32-bit chunks and drives it onto `sig` once the last chunk arrives. It also counts applied changes so a bench can compare driven changes against probe-detected changes. The block sits between a stimulus source (sequencer or DPI-fed FIFO) and the DUT signal under test. It is the "deposit" end of the same 32-bit-chunk value protocol that the probe reads.

## Interface
Parameters:
- `NBITS`, 1: width of the driven signal; legal range 1..1024.
- `NCHUNKS`, (NBITS+31)/32: derived, not overridable; number of 32-bit chunks per value.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  chunk offered on `wr_data`.
- `wr_ready`  out  1  block can accept a chunk this cycle.
- `wr_data`  in  32  chunk value; chunk 0 = bits [31:0], sent first.
- `wr_abort`  in  1  discard the partially collected value.
- `sig`  out  NBITS  driven signal.
- `sig_changed`  out  1  one-cycle pulse coincident with a counted commit.
- `change_count`  out  32  number of counted commits, wraps modulo 2^32.
- `chunk_idx`  out  clog2(NCHUNKS+1)  index of next chunk expected.
- `busy`  out  1  high when `chunk_idx` != 0 or state is COMMIT.

## Operation
- States:
  - IDLE: `chunk_idx` = 0.
  - COLLECT: `chunk_idx` > 0.
  - COMMIT: exactly one cycle.
- Transfer happens on an edge where `wr_valid && wr_ready`. The word is stored at staging slice [chunk_idx*32 +: 32], then `chunk_idx` increments.
- On transfer with `chunk_idx` == NCHUNKS-1: go to COMMIT and reset `chunk_idx` to 0. When NCHUNKS = 1, IDLE goes directly to COMMIT.
- COMMIT edge: `sig` <= staging[NBITS-1:0]. Staging bits at NBITS and above are ignored and never reach `sig`. `change_count` increments, `sig_changed` = 1 for one cycle, and the state returns to IDLE.
- `wr_ready` = 0 in COMMIT; 1 in IDLE and COLLECT.
- `wr_abort` sampled high in IDLE or COLLECT:
  - Clears staging and sets `chunk_idx` = 0.
  - Wins over a simultaneous transfer; the word is dropped.
  - `sig` and `change_count` are unaffected.
- `wr_abort` in COMMIT is ignored; the commit completes.
- `wr_data` is ignored when `wr_valid` = 0.

## Timing
- Reset values:
  - `sig` = 0, `sig_changed` = 0, `change_count` = 0, `chunk_idx` = 0.
  - `busy` = 0, `wr_ready` = 1, staging = 0, state IDLE.
- Reset asserted mid-collection or during COMMIT aborts immediately (asynchronous). No commit occurs and no pulse is produced.
- Latency: last chunk accepted at edge k gives new `sig` and `sig_changed` = 1 after edge k+1. `wr_ready` is low between k and k+1 and high again after k+1.
- Maximum throughput: one value per NCHUNKS+1 cycles.
- `change_count` wraps from 0xFFFFFFFF to 0 on the next counted commit. `sig_changed` still pulses on that commit.
- All outputs are registered. No combinational path from `wr_valid` to `wr_ready`.

## Configuration
- `CHUNK_DEPOSIT_FILTER_EN`:
  - Defined: a commit whose masked value equals current `sig` does not pulse `sig_changed` and does not increment `change_count`. The FSM still spends the COMMIT cycle. This makes `change_count` match the number of edges a probe can detect.
  - Undefined: every commit pulses and counts, including same-value commits.

## Test plan
- NBITS=1, write 0x1: `sig`=1 one cycle after acceptance, `sig_changed` pulses once, `change_count`=1. Then write 0x0: `sig`=0, `change_count`=2.
- NBITS=33:
  - Write 0xFFFFFFFF then 0x00000003: `sig`=33'h1_FFFF_FFFF; bit 1 of chunk 1 is discarded.
  - `wr_ready` low exactly one cycle after the second chunk.
  - `busy` high from the first acceptance through COMMIT.
- NBITS=32 with `wr_valid` held high and new data each cycle: values apply every 2 cycles, and no word is lost or duplicated.
- NBITS=33, abort after chunk 0 (concurrently offering a word): `chunk_idx`=0, `sig` unchanged, `change_count` unchanged. A following full two-chunk write commits correctly.
- Repeat-value write (0x5 twice, NBITS=4):
  - With `CHUNK_DEPOSIT_FILTER_EN`: `change_count`=1, one pulse.
  - Without it: `change_count`=2, two pulses.
- Assert `rst` during COMMIT and during COLLECT of NBITS=64: all outputs go to reset values immediately, and there is no `sig_changed` pulse on release.
